lcd_cell_writer: RTL and testbench
==================================

LCD_CELL_WRITER -- requirements
Module: lcd_cell_writer

Interface
REQ-001 Parameter CELL_PX, default 20, the cell edge length in pixels; 16x12 cells map onto a 320x240 panel.
REQ-002 clk  in  1  single system clock; all state updates on its rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 en_update  in  1  request to repaint one cell; sampled only in IDLE.
REQ-005 x  in  4  cell column (0..15).
REQ-006 y  in  4  cell row (0..11 valid).
REQ-007 obj_code  in  3  cell content code from the map scanner.
REQ-008 cmd_done  out  1  one-cycle pulse when the cell repaint is complete.
REQ-009 busy  out  1  high from request acceptance through the cmd_done cycle.
REQ-010 lcd_csx  out  1  panel chip select, active-low.
REQ-011 lcd_dcx  out  1  0 = command byte, 1 = data byte.
REQ-012 lcd_wrx  out  1  write strobe; the panel latches on its rising edge.
REQ-013 lcd_data  out  8  parallel 8080 bus byte.

Function
REQ-014 The FSM SHALL have these states: IDLE, CASET, PASET, RAMWR, PIXEL, DONE.
REQ-015 When en_update=1 in IDLE, the block SHALL latch x, y and obj_code at that edge (edge k) and leave IDLE; later input changes SHALL NOT affect the transaction.
REQ-016 Each bus byte SHALL take 2 cycles:
- phase A: lcd_wrx=0, with lcd_data and lcd_dcx valid;
- phase B: lcd_wrx=1, with lcd_data and lcd_dcx held.
REQ-017 The byte order SHALL be:
- 0x2A (dcx=0), then X0[15:8], X0[7:0], X1[15:8], X1[7:0];
- 0x2B (dcx=0), then Y0[15:8], Y0[7:0], Y1[15:8], Y1[7:0];
- 0x2C (dcx=0), then CELL_PX*CELL_PX pixels, each sent as colour[15:8] then colour[7:0] (dcx=1).
REQ-018 Address arithmetic SHALL be unsigned, zero-extended to 16 bits, with no overflow for legal inputs:
- X0 = x*CELL_PX, X1 = X0+CELL_PX-1;
- Y0 = y*CELL_PX, Y1 = Y0+CELL_PX-1.
REQ-019 The RGB565 colour map SHALL be: 000 0x0000, 001 0x07E0, 010 0x03E0, 011 0xF800, 100 0xFFFF, 101..111 0xF81F (error magenta).
REQ-020 With CELL_PX=20 the transfer is 811 bytes; write cycles SHALL occupy k+1..k+1622, and cmd_done=1 only in cycle k+1623 (state DONE).
REQ-021 lcd_csx SHALL be 0 from cycle k+1 through k+1622, and 1 in DONE and IDLE.
REQ-022 busy SHALL be 1 for cycles k+1..k+1623.
REQ-023 en_update while busy SHALL be ignored and SHALL NOT be queued.
REQ-024 A request held high through DONE SHALL be accepted at the first edge back in IDLE (k+1624).
REQ-025 If the latched y>11, the block SHALL emit no bus bytes and SHALL keep lcd_csx=1; cmd_done SHALL pulse in cycle k+1.
REQ-026 The pixel counter SHALL count 0..CELL_PX*CELL_PX-1 with no wrap; the transition to DONE SHALL occur after phase B of the last low byte.

Reset
REQ-027 While rst=1, from any state, the block SHALL go to IDLE with: lcd_csx=1, lcd_wrx=1, lcd_dcx=1, lcd_data=0x00, busy=0, cmd_done=0, and all counters 0.
REQ-028 A reset mid-transfer SHALL abort the transfer; no cmd_done SHALL be produced for the aborted request.
REQ-029 The first request after rst deasserts SHALL start with 0x2A.

Verification
REQ-030 Scenario, reset: assert rst mid-cycle -> outputs immediately at REQ-027 values, before any clock edge.
REQ-031 Scenario, top-left border cell: x=0, y=0, obj_code=100 -> bytes 2A 00 00 00 13 2B 00 00 00 13 2C, then 800 x FF; cmd_done exactly at k+1623.
REQ-032 Scenario, bottom-right apple cell: x=15, y=11, obj_code=011 -> bytes 2A 01 2C 01 3F 2B 00 DC 00 EF 2C, then 400 x (F8, 00).
REQ-033 Scenario, request during busy: pulse en_update at k+500 with other x/y -> ignored, single cmd_done; en_update held high -> second request accepted at k+1624.
REQ-034 Scenario, invalid row and error code:
- y=12 -> no wrx pulses, cmd_done at k+1;
- obj_code=110, x=3, y=2 -> 400 x (F8, 1F), X0=0x003C, Y0=0x0028.
REQ-035 Scenario, reset mid-pixel: rst pulsed at k+900 -> csx=1 immediately, no cmd_done; the next request restarts with 0x2A.

Source files
------------

// File: rtl/lcd_cell_writer.sv
// Repaints one map cell on an 8080-bus LCD panel: a column window, a row window,
// then a memory write of CELL_PX*CELL_PX RGB565 pixels in the cell's colour.
module lcd_cell_writer #(
  parameter int CELL_PX = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_update,
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic [2:0] obj_code,
  output logic       cmd_done,
  output logic       busy,
  output logic       lcd_csx,
  output logic       lcd_dcx,
  output logic       lcd_wrx,
  output logic [7:0] lcd_data
);

  localparam int          NPIX     = CELL_PX * CELL_PX;
  localparam logic [15:0] CELL     = 16'(CELL_PX);
  localparam logic [15:0] LAST_PIX = 16'(NPIX - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CASET = 3'd1,
    PASET = 3'd2,
    RAMWR = 3'd3,
    PIXEL = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state;
  logic [3:0]  cell_x;
  logic [3:0]  cell_y;
  logic [2:0]  code;
  logic [2:0]  byte_idx;
  logic [15:0] pix_cnt;
  logic        lo_byte;

  logic [15:0] x0;
  logic [15:0] x1;
  logic [15:0] y0;
  logic [15:0] y1;
  logic [15:0] colour;

  function automatic logic [15:0] colour_of(input logic [2:0] c);
    logic [15:0] rgb;
    case (c)
      3'b000:  rgb = 16'h0000;
      3'b001:  rgb = 16'h07E0;
      3'b010:  rgb = 16'h03E0;
      3'b011:  rgb = 16'hF800;
      3'b100:  rgb = 16'hFFFF;
      default: rgb = 16'hF81F;
    endcase
    return rgb;
  endfunction

  // Parameter bytes 1..4 of a window command: start hi/lo, end hi/lo.
  function automatic logic [7:0] addr_byte(input logic [15:0] a0, input logic [15:0] a1,
                                           input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd1:    b = a0[15:8];
      3'd2:    b = a0[7:0];
      3'd3:    b = a1[15:8];
      3'd4:    b = a1[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Window corners and colour derived from the latched request.
  always_comb begin
    x0     = {12'd0, cell_x} * CELL;
    x1     = x0 + CELL - 16'd1;
    y0     = {12'd0, cell_y} * CELL;
    y1     = y0 + CELL - 16'd1;
    colour = colour_of(code);
  end

  // Transaction FSM; every bus byte is a wrx-low phase followed by a wrx-high phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cell_x   <= 4'd0;
      cell_y   <= 4'd0;
      code     <= 3'd0;
      byte_idx <= 3'd0;
      pix_cnt  <= 16'd0;
      lo_byte  <= 1'b0;
      cmd_done <= 1'b0;
      busy     <= 1'b0;
      lcd_csx  <= 1'b1;
      lcd_dcx  <= 1'b1;
      lcd_wrx  <= 1'b1;
      lcd_data <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          cmd_done <= 1'b0;
          if (en_update) begin
            cell_x   <= x;
            cell_y   <= y;
            code     <= obj_code;
            busy     <= 1'b1;
            byte_idx <= 3'd0;
            pix_cnt  <= 16'd0;
            lo_byte  <= 1'b0;
            if (y > 4'd11) begin
              // Off-panel row: finish without touching the bus.
              state    <= DONE;
              cmd_done <= 1'b1;
            end else begin
              state    <= CASET;
              lcd_csx  <= 1'b0;
              lcd_wrx  <= 1'b0;
              lcd_dcx  <= 1'b0;
              lcd_data <= 8'h2A;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        CASET: begin
          if (!lcd_wrx) begin
            lcd_wrx <= 1'b1;
          end else if (byte_idx != 3'd4) begin
            byte_idx <= byte_idx + 3'd1;
            lcd_data <= addr_byte(x0, x1, byte_idx + 3'd1);
            lcd_dcx  <= 1'b1;
            lcd_wrx  <= 1'b0;
          end else begin
            state    <= PASET;
            byte_idx <= 3'd0;
            lcd_data <= 8'h2B;
            lcd_dcx  <= 1'b0;
            lcd_wrx  <= 1'b0;
          end
        end
        PASET: begin
          if (!lcd_wrx) begin
            lcd_wrx <= 1'b1;
          end else if (byte_idx != 3'd4) begin
            byte_idx <= byte_idx + 3'd1;
            lcd_data <= addr_byte(y0, y1, byte_idx + 3'd1);
            lcd_dcx  <= 1'b1;
            lcd_wrx  <= 1'b0;
          end else begin
            state    <= RAMWR;
            byte_idx <= 3'd0;
            lcd_data <= 8'h2C;
            lcd_dcx  <= 1'b0;
            lcd_wrx  <= 1'b0;
          end
        end
        RAMWR: begin
          if (!lcd_wrx) begin
            lcd_wrx <= 1'b1;
          end else begin
            state    <= PIXEL;
            pix_cnt  <= 16'd0;
            lo_byte  <= 1'b0;
            lcd_data <= colour[15:8];
            lcd_dcx  <= 1'b1;
            lcd_wrx  <= 1'b0;
          end
        end
        PIXEL: begin
          if (!lcd_wrx) begin
            lcd_wrx <= 1'b1;
          end else if (!lo_byte) begin
            lo_byte  <= 1'b1;
            lcd_data <= colour[7:0];
            lcd_wrx  <= 1'b0;
          end else if (pix_cnt == LAST_PIX) begin
            state    <= DONE;
            cmd_done <= 1'b1;
            pix_cnt  <= 16'd0;
            lo_byte  <= 1'b0;
            lcd_csx  <= 1'b1;
            lcd_dcx  <= 1'b1;
            lcd_data <= 8'h00;
          end else begin
            pix_cnt  <= pix_cnt + 16'd1;
            lo_byte  <= 1'b0;
            lcd_data <= colour[15:8];
            lcd_wrx  <= 1'b0;
          end
        end
        DONE: begin
          state    <= IDLE;
          cmd_done <= 1'b0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cmd_done <= 1'b0;
          busy     <= 1'b0;
          lcd_csx  <= 1'b1;
          lcd_dcx  <= 1'b1;
          lcd_wrx  <= 1'b1;
          lcd_data <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_cell_writer.sv
// Directed bench for lcd_cell_writer: captures every bus byte and compares
// against hand-computed window addresses, colours and cycle timing.
module tb_lcd_cell_writer;

  localparam int NPIX = 400;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en_update = 1'b0;
  logic [3:0] x = 4'd0;
  logic [3:0] y = 4'd0;
  logic [2:0] obj_code = 3'd0;
  logic       cmd_done;
  logic       busy;
  logic       lcd_csx;
  logic       lcd_dcx;
  logic       lcd_wrx;
  logic [7:0] lcd_data;

  int total = 0;
  int bad = 0;
  int edge_n = 0;
  int csx_low = 0;
  int busy_cnt = 0;
  logic [8:0] q[$];

  lcd_cell_writer #(.CELL_PX(20)) dut (
    .clk(clk), .rst(rst), .en_update(en_update), .x(x), .y(y), .obj_code(obj_code),
    .cmd_done(cmd_done), .busy(busy), .lcd_csx(lcd_csx), .lcd_dcx(lcd_dcx),
    .lcd_wrx(lcd_wrx), .lcd_data(lcd_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  // Bus monitor: one entry {dcx,data} per write-low phase.
  initial forever begin
    @(negedge clk);
    if (!lcd_csx && !lcd_wrx) q.push_back({lcd_dcx, lcd_data});
    if (!lcd_csx) csx_low++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_req(input logic [3:0] rx, input logic [3:0] ry, input logic [2:0] ro,
                        output int k);
    @(negedge clk);
    q.delete();
    csx_low = 0;
    busy_cnt = 0;
    x = rx;
    y = ry;
    obj_code = ro;
    en_update = 1'b1;
    k = edge_n + 1;
    @(posedge clk);
    #1;
    en_update = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int k, input int off);
    int got;
    got = -1;
    for (int i = 0; i < 2500 && got < 0; i++) begin
      @(negedge clk);
      if (cmd_done) got = edge_n - k;
    end
    check(tag, got, off);
    @(negedge clk);
  endtask

  task automatic check_xfer(input string tag, input logic [10:0][7:0] hdr, input logic [15:0] col);
    int errs;
    logic [8:0] e;
    check({tag, "_nbytes"}, q.size(), 11 + 2 * NPIX);
    for (int i = 0; i < 11; i++) begin
      e = {(i == 0 || i == 5 || i == 10) ? 1'b0 : 1'b1, hdr[10-i]};
      if (i < q.size()) check($sformatf("%s_hdr%0d", tag, i), int'(q[i]), int'(e));
    end
    errs = 0;
    for (int i = 11; i < q.size(); i++) begin
      e = {1'b1, ((i - 11) % 2 == 0) ? col[15:8] : col[7:0]};
      if (q[i] !== e) errs++;
    end
    check({tag, "_pix_errs"}, errs, 0);
  endtask

  initial begin
    int k;
    int got;
    int n;

    // Reset asserted between edges must force idle outputs at once.
    #2 rst = 1'b1;
    #1;
    check("rst_csx", lcd_csx, 1);
    check("rst_wrx", lcd_wrx, 1);
    check("rst_dcx", lcd_dcx, 1);
    check("rst_data", lcd_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", cmd_done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Top-left border cell.
    do_req(4'd0, 4'd0, 3'b100, k);
    wait_done("tl_done_cyc", k, 1622);
    check_xfer("tl", {8'h2A, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2C},
               16'hFFFF);
    check("tl_csx_low_cycles", csx_low, 1622);
    check("tl_busy_cycles", busy_cnt, 1623);

    // Bottom-right apple cell.
    do_req(4'd15, 4'd11, 3'b011, k);
    wait_done("br_done_cyc", k, 1622);
    check_xfer("br", {8'h2A, 8'h01, 8'h2C, 8'h01, 8'h3F, 8'h2B, 8'h00, 8'hDC, 8'h00, 8'hEF, 8'h2C},
               16'hF800);

    // Request pulsed while busy is dropped.
    do_req(4'd1, 4'd1, 3'b000, k);
    while (edge_n < k + 499) @(negedge clk);
    x = 4'd5;
    y = 4'd5;
    en_update = 1'b1;
    @(posedge clk);
    #1;
    en_update = 1'b0;
    wait_done("busy_done_cyc", k, 1622);
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (cmd_done) n++;
    end
    check("busy_extra_done", n, 0);
    check_xfer("busy", {8'h2A, 8'h00, 8'h14, 8'h00, 8'h27, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h27, 8'h2C},
               16'h0000);

    // Request held high through DONE is accepted one idle cycle later.
    @(negedge clk);
    q.delete();
    x = 4'd2;
    y = 4'd0;
    obj_code = 3'b001;
    en_update = 1'b1;
    k = edge_n + 1;
    got = -1;
    for (int i = 0; i < 2500 && got < 0; i++) begin
      @(negedge clk);
      if (cmd_done) got = edge_n - k;
    end
    check("hold_done_cyc", got, 1622);
    @(negedge clk);
    check("hold_idle_busy", busy, 0);
    @(negedge clk);
    check("hold_accept_busy", busy, 1);
    check("hold_accept_byte", int'({lcd_dcx, lcd_wrx, lcd_data}), int'(10'h02A));
    en_update = 1'b0;
    wait_done("hold_done2_cyc", k + 1624, 1622);

    // Off-panel row.
    do_req(4'd4, 4'd12, 3'b001, k);
    wait_done("bady_done_cyc", k, 0);
    check("bady_nbytes", q.size(), 0);
    check("bady_csx_low", csx_low, 0);

    // Error code with nonzero window.
    do_req(4'd3, 4'd2, 3'b110, k);
    wait_done("err_done_cyc", k, 1622);
    check_xfer("err", {8'h2A, 8'h00, 8'h3C, 8'h00, 8'h4F, 8'h2B, 8'h00, 8'h28, 8'h00, 8'h3B, 8'h2C},
               16'hF81F);

    // Reset in the middle of the pixel stream aborts without cmd_done.
    do_req(4'd4, 4'd4, 3'b010, k);
    while (edge_n < k + 899) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_csx", lcd_csx, 1);
    check("abort_busy", busy, 0);
    check("abort_wrx", lcd_wrx, 1);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    repeat (1800) begin
      @(negedge clk);
      if (cmd_done) n++;
    end
    check("abort_no_done", n, 0);
    do_req(4'd0, 4'd1, 3'b101, k);
    wait_done("restart_done_cyc", k, 1622);
    check_xfer("restart", {8'h2A, 8'h00, 8'h00, 8'h00, 8'h13, 8'h2B, 8'h00, 8'h14, 8'h00, 8'h27, 8'h2C},
               16'hF81F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
